// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the transmit frame scheduler and the sample generators it feeds.
// State encoding and default frame geometry live here so the generators agree with the scheduler.
package frame_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREAMB  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } fs_state_e;

    localparam int DEF_PREAMB_LEN = 320;
    localparam int DEF_SYM_LEN    = 80;
    localparam int DEF_GAP_LEN    = 16;
    localparam int DEF_CNT_W      = 10;
    localparam int DEF_SYM_W      = 8;

endpackage

// File: rtl/frame_scheduler.sv
// Frame sequencer: preamble, N OFDM symbols, optional inter-frame gap, repeat.
// Define FRAME_SCHED_GAP_EN to insert GAP_LEN idle cycles between frames; otherwise frames run back-to-back.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int PREAMB_LEN = DEF_PREAMB_LEN,
    parameter int SYM_LEN    = DEF_SYM_LEN,
    parameter int GAP_LEN    = DEF_GAP_LEN,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SYM_W      = DEF_SYM_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             ready_in,
    input  logic [SYM_W-1:0] n_sym_cfg,
    output logic             ready_out,
    output logic             control,
    output logic             sop_preamb,
    output logic             sop_sym,
    output logic             eop,
    output logic [SYM_W-1:0] sym_idx,
    output logic             busy
);

    localparam logic [CNT_W-1:0] PREAMB_LAST = CNT_W'(PREAMB_LEN - 1);
    localparam logic [CNT_W-1:0] SYM_LAST    = CNT_W'(SYM_LEN - 1);
`ifdef FRAME_SCHED_GAP_EN
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_LEN - 1);
`endif

    fs_state_e        state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [SYM_W-1:0] sym_idx_r, sym_idx_n;
    logic [SYM_W-1:0] nsym_r, nsym_n;
    logic             control_r;
    logic             beat_s, preamb_last_s, sym_last_s, frame_end_s;

    // Accepted-sample qualifier and last-sample-of-frame detection
    always_comb begin
        beat_s        = enable & ready_in & ((state_r == ST_PREAMB) | (state_r == ST_PAYLOAD));
        preamb_last_s = (cnt_r == PREAMB_LAST);
        sym_last_s    = (cnt_r == SYM_LAST);
        frame_end_s   = beat_s &
                        (((state_r == ST_PREAMB) & preamb_last_s & (nsym_r == {SYM_W{1'b0}})) |
                         ((state_r == ST_PAYLOAD) & sym_last_s & (sym_idx_r == nsym_r - SYM_W'(1))));
    end

    // Next-state and counter logic; a new frame always relatches the symbol count
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        sym_idx_n = sym_idx_r;
        nsym_n    = nsym_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_n   = ST_PREAMB;
                    cnt_n     = {CNT_W{1'b0}};
                    sym_idx_n = {SYM_W{1'b0}};
                    nsym_n    = n_sym_cfg;
                end else begin
                    state_n   = ST_IDLE;
                end
            end
            ST_PREAMB, ST_PAYLOAD: begin
                if (frame_end_s) begin
`ifdef FRAME_SCHED_GAP_EN
                    state_n = ST_GAP;
                    cnt_n   = {CNT_W{1'b0}};
`else
                    if (enable) begin
                        state_n   = ST_PREAMB;
                        cnt_n     = {CNT_W{1'b0}};
                        sym_idx_n = {SYM_W{1'b0}};
                        nsym_n    = n_sym_cfg;
                    end else begin
                        state_n   = ST_IDLE;
                        cnt_n     = {CNT_W{1'b0}};
                    end
`endif
                end else if (beat_s) begin
                    if ((state_r == ST_PREAMB) && preamb_last_s) begin
                        state_n = ST_PAYLOAD;
                        cnt_n   = {CNT_W{1'b0}};
                    end else if ((state_r == ST_PAYLOAD) && sym_last_s) begin
                        cnt_n     = {CNT_W{1'b0}};
                        sym_idx_n = sym_idx_r + SYM_W'(1);
                    end else begin
                        cnt_n = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_n = cnt_r;
                end
            end
`ifdef FRAME_SCHED_GAP_EN
            ST_GAP: begin
                // The gap counts wall-clock cycles, so ready_in plays no part here
                if (enable) begin
                    if (cnt_r == GAP_LAST) begin
                        state_n   = ST_PREAMB;
                        cnt_n     = {CNT_W{1'b0}};
                        sym_idx_n = {SYM_W{1'b0}};
                        nsym_n    = n_sym_cfg;
                    end else begin
                        cnt_n = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_n = cnt_r;
                end
            end
`endif
            default: begin
                state_n   = ST_IDLE;
                cnt_n     = {CNT_W{1'b0}};
                sym_idx_n = {SYM_W{1'b0}};
                nsym_n    = {SYM_W{1'b0}};
            end
        endcase
    end

    // State and counter registers; control tracks the state being entered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            sym_idx_r <= {SYM_W{1'b0}};
            nsym_r    <= {SYM_W{1'b0}};
            control_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            sym_idx_r <= sym_idx_n;
            nsym_r    <= nsym_n;
            control_r <= (state_n == ST_PREAMB);
        end
    end

    assign ready_out  = beat_s;
    assign sop_preamb = beat_s & (state_r == ST_PREAMB) & (cnt_r == {CNT_W{1'b0}});
    assign sop_sym    = beat_s & (state_r == ST_PAYLOAD) & (cnt_r == {CNT_W{1'b0}});
    assign eop        = frame_end_s;
    assign control    = control_r;
    assign sym_idx    = sym_idx_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: frame-position model plus directed literal checks.
// Honours FRAME_SCHED_GAP_EN the same way as the design.
module tb_frame_scheduler;

    localparam int PL    = 4;
    localparam int SL    = 3;
    localparam int GL    = 2;
    localparam int SYM_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             ready_in = 1'b0;
    logic [SYM_W-1:0] n_sym_cfg = 8'd0;
    logic             ready_out, control, sop_preamb, sop_sym, eop, busy;
    logic [SYM_W-1:0] sym_idx;

    int n_checks = 0;
    int n_fail   = 0;

    frame_scheduler #(
        .PREAMB_LEN(PL), .SYM_LEN(SL), .GAP_LEN(GL), .CNT_W(3), .SYM_W(SYM_W)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .ready_in(ready_in),
        .n_sym_cfg(n_sym_cfg), .ready_out(ready_out), .control(control),
        .sop_preamb(sop_preamb), .sop_sym(sop_sym), .eop(eop),
        .sym_idx(sym_idx), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0=idle 1=in frame 2=gap; pos is the sample index within the frame
    int m_phase = 0, m_pos = 0, m_nsym = 0, m_g = 0, m_sym = 0;

    function automatic int flen(input int ns);
        return PL + ns * SL;
    endfunction

    function automatic int sym_of(input int p);
        return (p < PL) ? 0 : (p - PL) / SL;
    endfunction

    // Model state advances on each accepted sample / gap cycle
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_pos <= 0; m_nsym <= 0; m_g <= 0; m_sym <= 0;
        end else begin
            case (m_phase)
                0: if (enable) begin
                    m_phase <= 1; m_pos <= 0; m_nsym <= int'(n_sym_cfg); m_sym <= 0;
                end
                1: if (enable && ready_in) begin
                    if (m_pos == flen(m_nsym) - 1) begin
`ifdef FRAME_SCHED_GAP_EN
                        m_phase <= 2; m_g <= 0;
`else
                        m_pos <= 0; m_nsym <= int'(n_sym_cfg); m_sym <= 0;
`endif
                    end else begin
                        m_pos <= m_pos + 1; m_sym <= sym_of(m_pos + 1);
                    end
                end
                2: if (enable) begin
                    if (m_g == GL - 1) begin
                        m_phase <= 1; m_pos <= 0; m_nsym <= int'(n_sym_cfg); m_sym <= 0;
                    end else begin
                        m_g <= m_g + 1;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clock) begin
        bit b;
        b = enable && ready_in && (m_phase == 1);
        chk("model_ready_out", int'(ready_out), int'(b));
        chk("model_control", int'(control), int'(m_phase == 1 && m_pos < PL));
        chk("model_sop_preamb", int'(sop_preamb), int'(b && m_pos == 0));
        chk("model_sop_sym", int'(sop_sym), int'(b && m_pos >= PL && ((m_pos - PL) % SL) == 0));
        chk("model_eop", int'(eop), int'(b && m_pos == flen(m_nsym) - 1));
        chk("model_sym_idx", int'(sym_idx), m_sym);
        chk("model_busy", int'(busy), int'(m_phase != 0));
    end

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic restart();
        @(negedge clock);
        #2;
        reset = 1'b1; enable = 1'b0; ready_in = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_to_eop(output int beats, output int idx_at_eop);
        bit found = 1'b0;
        beats = 0; idx_at_eop = -1;
        for (int c = 0; c < 200 && !found; c++) begin
            sample();
            if (ready_out) beats++;
            if (eop) begin found = 1'b1; idx_at_eop = int'(sym_idx); end
            next_cycle();
        end
        chk("eop_within_bound", int'(found), 1);
    endtask

    initial begin
        int beat, n, idx;
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_control", int'(control), 0);
        chk("rst_ready_out", int'(ready_out), 0);
        chk("rst_sym_idx", int'(sym_idx), 0);
        @(posedge clock); #1; reset = 1'b0;

        // 1: continuous flow, nsym=2
        restart();
        n_sym_cfg = 8'd2; enable = 1'b1; ready_in = 1'b1;
        sample(); chk("t1_idle_busy", int'(busy), 0); chk("t1_idle_ready", int'(ready_out), 0);
        next_cycle();
        for (int b = 1; b <= 10; b++) begin
            sample();
            chk("t1_sop_preamb", int'(sop_preamb), int'(b == 1));
            chk("t1_sop_sym", int'(sop_sym), int'(b == 5 || b == 8));
            chk("t1_eop", int'(eop), int'(b == 10));
            chk("t1_control", int'(control), int'(b <= 4));
            chk("t1_sym_idx", int'(sym_idx), int'(b >= 8));
            next_cycle();
        end
`ifdef FRAME_SCHED_GAP_EN
        for (int g = 0; g < GL; g++) begin
            sample();
            chk("t1_gap_ready", int'(ready_out), 0);
            chk("t1_gap_busy", int'(busy), 1);
            chk("t1_gap_control", int'(control), 0);
            next_cycle();
        end
`endif
        sample(); chk("t1_next_sop_preamb", int'(sop_preamb), 1); chk("t1_next_control", int'(control), 1);
        next_cycle();

        // 2: ready toggling every cycle
        restart();
        n_sym_cfg = 8'd2; enable = 1'b1; ready_in = 1'b0;
        sample(); next_cycle();
        beat = 0;
        for (int c = 0; c < 40 && beat < 10; c++) begin
            ready_in = (c % 2 == 0);
            sample();
            if (ready_in) begin
                beat++;
                chk("t2_sop_preamb", int'(sop_preamb), int'(beat == 1));
                chk("t2_sop_sym", int'(sop_sym), int'(beat == 5 || beat == 8));
                chk("t2_eop", int'(eop), int'(beat == 10));
            end else begin
                chk("t2_stall_ready", int'(ready_out), 0);
                chk("t2_stall_pulses", int'(sop_preamb | sop_sym | eop), 0);
            end
            next_cycle();
        end
        chk("t2_beats", beat, 10);

        // 3: preamble-only frame
        restart();
        n_sym_cfg = 8'd0; enable = 1'b1; ready_in = 1'b1;
        sample(); next_cycle();
        for (int b = 1; b <= 4; b++) begin
            sample();
            chk("t3_control", int'(control), 1);
            chk("t3_eop", int'(eop), int'(b == 4));
            chk("t3_sop_sym", int'(sop_sym), 0);
            next_cycle();
            n_sym_cfg = 8'd2;
        end
`ifndef FRAME_SCHED_GAP_EN
        sample(); chk("t3_next_sop_preamb", int'(sop_preamb), 1); chk("t3_next_control", int'(control), 1);
        next_cycle();
`endif

        // 4: stall mid-symbol at sym_idx=1, cnt=1
        restart();
        n_sym_cfg = 8'd2; enable = 1'b1; ready_in = 1'b1;
        sample(); next_cycle();
        for (int b = 1; b <= 8; b++) begin sample(); next_cycle(); end
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("t4_hold_ready", int'(ready_out), 0);
            chk("t4_hold_sym_idx", int'(sym_idx), 1);
            chk("t4_hold_control", int'(control), 0);
            chk("t4_hold_busy", int'(busy), 1);
            chk("t4_hold_pulses", int'(sop_sym | eop), 0);
            next_cycle();
        end
        enable = 1'b1;
        sample(); chk("t4_resume_ready", int'(ready_out), 1); chk("t4_resume_eop", int'(eop), 0);
        next_cycle();
        sample(); chk("t4_final_eop", int'(eop), 1); chk("t4_final_sym_idx", int'(sym_idx), 1);
        next_cycle();

        // 5: n_sym_cfg changes mid-frame
        restart();
        n_sym_cfg = 8'd2; enable = 1'b1; ready_in = 1'b1;
        sample(); next_cycle();
        for (int b = 1; b <= 3; b++) begin sample(); next_cycle(); end
        n_sym_cfg = 8'd5;
        run_to_eop(n, idx);
        chk("t5_frame1_rest", n, 7); chk("t5_frame1_idx", idx, 1);
        run_to_eop(n, idx);
        chk("t5_frame2_beats", n, 19); chk("t5_frame2_idx", idx, 4);

        // 6: reset mid-payload clears outputs immediately
        restart();
        n_sym_cfg = 8'd2; enable = 1'b1; ready_in = 1'b1;
        sample(); next_cycle();
        for (int b = 1; b <= 5; b++) begin sample(); next_cycle(); end
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_ready", int'(ready_out), 0);
        chk("t6_control", int'(control), 0);
        chk("t6_eop", int'(eop), 0);
        chk("t6_sym_idx", int'(sym_idx), 0);
        @(posedge clock); #1; reset = 1'b0;

        // Mixed stall pattern, checked by the model
        restart();
        for (int c = 0; c < 300; c++) begin
            enable    = (c % 17 != 3);
            ready_in  = (c % 5 != 2);
            n_sym_cfg = 8'((c / 40) % 4);
            sample();
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
